// File: rtl/mdu_pkg.sv
// Shared MDU opcode encodings and opcode-class helpers.
// Codes 6 and 7 are reserved and decode as no-ops.
package mdu_pkg;

    localparam logic [2:0] MDOp_MULT  = 3'd0;
    localparam logic [2:0] MDOp_MULTU = 3'd1;
    localparam logic [2:0] MDOp_DIV   = 3'd2;
    localparam logic [2:0] MDOp_DIVU  = 3'd3;
    localparam logic [2:0] MDOp_MTHI  = 3'd4;
    localparam logic [2:0] MDOp_MTLO  = 3'd5;

    function automatic logic op_is_muldiv(input logic [2:0] op);
        return (op == MDOp_MULT) || (op == MDOp_MULTU) ||
               (op == MDOp_DIV)  || (op == MDOp_DIVU);
    endfunction

    function automatic logic op_is_div(input logic [2:0] op);
        return (op == MDOp_DIV) || (op == MDOp_DIVU);
    endfunction

    function automatic logic op_is_signed(input logic [2:0] op);
        return (op == MDOp_MULT) || (op == MDOp_DIV);
    endfunction

endpackage

// File: rtl/mdu_step.sv
// One iteration of the MDU datapath: shift-add multiply or restoring divide
// on a shared 2W-bit accumulator ({upper, lower} = {partial, multiplier} or {remainder, quotient}).
module mdu_step
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 is_div,
    input  logic [2*WIDTH-1:0]   acc,
    input  logic [WIDTH-1:0]     opnd,
    output logic [2*WIDTH-1:0]   acc_next
);

    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   shifted_s;
    logic [WIDTH:0]   diff_s;
    logic             ge_s;

    // Both step flavours are computed; is_div selects which one advances the accumulator.
    always_comb begin
        sum_s     = {1'b0, acc[2*WIDTH-1:WIDTH]} +
                    (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
        shifted_s = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        ge_s      = (shifted_s >= {1'b0, opnd});
        diff_s    = shifted_s - {1'b0, opnd};
        if (is_div) begin
            // A zero divisor always "fits", yielding all-ones quotient and remainder = dividend.
            if (ge_s) begin
                acc_next = {diff_s[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = {shifted_s[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_next = {sum_s, acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mdu.sv
// Iterative multiply/divide unit with HI/LO registers and start/busy/done handshake.
// Signed ops run on magnitudes and fix up signs in a final FIX cycle.
module mdu
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start,
    input  logic [2:0]         op,
    input  logic               flush,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     opnd_q, opnd_d;
    logic                 is_div_q, is_div_d;
    logic                 pneg_q, pneg_d;
    logic                 rneg_q, rneg_d;
    logic                 dbz_q, dbz_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;

    logic                 sgn_s;
    logic [WIDTH-1:0]     a_mag_s;
    logic [WIDTH-1:0]     b_mag_s;
    logic [2*WIDTH-1:0]   step_s;
    logic [2*WIDTH-1:0]   prod_s;
    logic [WIDTH-1:0]     quo_s;
    logic [WIDTH-1:0]     rem_s;

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .is_div   (is_div_q),
        .acc      (acc_q),
        .opnd     (opnd_q),
        .acc_next (step_s)
    );

    // Next-state logic for the IDLE/CALC/FIX sequencer and the HI/LO result registers.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        is_div_d = is_div_q;
        pneg_d   = pneg_q;
        rneg_d   = rneg_q;
        dbz_d    = dbz_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        hi_d     = hi_q;
        lo_d     = lo_q;

        sgn_s   = op_is_signed(op);
        a_mag_s = (sgn_s && A[WIDTH-1]) ? -A : A;
        b_mag_s = (sgn_s && B[WIDTH-1]) ? -B : B;
        prod_s  = pneg_q ? -acc_q : acc_q;
        quo_s   = acc_q[WIDTH-1:0];
        rem_s   = acc_q[2*WIDTH-1:WIDTH];

        case (state_q)
            S_IDLE: begin
                if (flush) begin
                    busy_d = 1'b0;
                end else if (start && op_is_muldiv(op)) begin
                    is_div_d = op_is_div(op);
                    pneg_d   = sgn_s && (A[WIDTH-1] ^ B[WIDTH-1]);
                    rneg_d   = sgn_s && A[WIDTH-1];
                    dbz_d    = (B == {WIDTH{1'b0}});
                    acc_d    = op_is_div(op) ? {{WIDTH{1'b0}}, a_mag_s}
                                             : {{WIDTH{1'b0}}, b_mag_s};
                    opnd_d   = op_is_div(op) ? b_mag_s : a_mag_s;
                    cnt_d    = {CNT_W{1'b0}};
                    busy_d   = 1'b1;
                    state_d  = S_CALC;
                end else if (start && (op == MDOp_MTHI)) begin
                    hi_d   = A;
                    done_d = 1'b1;
                end else if (start && (op == MDOp_MTLO)) begin
                    lo_d   = A;
                    done_d = 1'b1;
                end else begin
                    busy_d = 1'b0;
                end
            end
            S_CALC: begin
                if (flush) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    acc_d = step_s;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d = S_FIX;
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end
            S_FIX: begin
                if (flush) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    if (is_div_q) begin
                        lo_d = dbz_q ? {WIDTH{1'b1}} : (pneg_q ? -quo_s : quo_s);
                        hi_d = rneg_q ? -rem_s : rem_s;
                    end else begin
                        {hi_d, lo_d} = prod_s;
                    end
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; rstn clears everything immediately, even mid-operation.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            cnt_q    <= {CNT_W{1'b0}};
            acc_q    <= {(2*WIDTH){1'b0}};
            opnd_q   <= {WIDTH{1'b0}};
            is_div_q <= 1'b0;
            pneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            dbz_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= {WIDTH{1'b0}};
            lo_q     <= {WIDTH{1'b0}};
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            is_div_q <= is_div_d;
            pneg_q   <= pneg_d;
            rneg_q   <= rneg_d;
            dbz_q    <= dbz_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Directed self-checking bench for mdu at WIDTH=32, plus a WIDTH=8 sweep against an arithmetic model.
module tb_mdu;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0, flush = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] A = 32'd0, B = 32'd0;
    logic        busy, done;
    logic [31:0] hi, lo;

    logic        start8 = 1'b0, flush8 = 1'b0;
    logic [2:0]  op8 = 3'd0;
    logic [7:0]  a8 = 8'd0, b8 = 8'd0;
    logic        busy8, done8;
    logic [7:0]  hi8, lo8;

    int checks = 0;
    int errors = 0;
    int lat;
    int done_seen;

    mdu #(.WIDTH(32)) u_dut (
        .clk(clk), .rstn(rstn), .start(start), .op(op), .flush(flush),
        .A(A), .B(B), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    mdu #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rstn(rstn), .start(start8), .op(op8), .flush(flush8),
        .A(a8), .B(b8), .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run32(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk); start = 1'b1; op = o; A = a; B = b;
        @(negedge clk); start = 1'b0; lat = 0;
        while (done !== 1'b1 && lat < 60) begin
            @(negedge clk); lat++;
        end
    endtask

    task automatic expect32(input string tag, input logic [31:0] ehi, input logic [31:0] elo);
        check({tag, "_lat"}, 64'(lat), 64'd33);
        check({tag, "_hi"}, {32'd0, hi}, {32'd0, ehi});
        check({tag, "_lo"}, {32'd0, lo}, {32'd0, elo});
        @(negedge clk);
        check({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
    endtask

    function automatic logic [15:0] ref8(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
        int sa, sb, ua, ub, r, q, m;
        sa = $signed(a); sb = $signed(b); ua = a; ub = b;
        case (o)
            MDOp_MULT:  begin r = sa * sb; return r[15:0]; end
            MDOp_MULTU: begin r = ua * ub; return r[15:0]; end
            MDOp_DIV: begin
                if (b == 8'd0) return {a, 8'hFF};
                q = sa / sb; m = sa % sb;
                return {m[7:0], q[7:0]};
            end
            MDOp_DIVU: begin
                if (b == 8'd0) return {a, 8'hFF};
                q = ua / ub; m = ua % ub;
                return {m[7:0], q[7:0]};
            end
            default: return 16'd0;
        endcase
    endfunction

    logic [7:0] va [10] = '{8'h80, 8'h7F, 8'hF9, 8'h35, 8'hC8, 8'h80, 8'h00, 8'hFF, 8'h00, 8'h00};
    logic [7:0] vb [10] = '{8'hFF, 8'h03, 8'h02, 8'h00, 8'hF3, 8'h80, 8'h05, 8'hFF, 8'h00, 8'h00};
    logic [2:0] ops8 [4] = '{MDOp_MULT, MDOp_MULTU, MDOp_DIV, MDOp_DIVU};

    initial begin
        repeat (2) @(negedge clk);
        check("reset_hi", {32'd0, hi}, 64'd0);
        check("reset_lo", {32'd0, lo}, 64'd0);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        rstn = 1'b1;

        // Main function at WIDTH=32
        @(negedge clk); start = 1'b1; op = MDOp_MULTU; A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF;
        @(negedge clk); start = 1'b0; lat = 0;
        check("multu_busy_e0", {63'd0, busy}, 64'd1);
        while (done !== 1'b1 && lat < 60) begin
            @(negedge clk); lat++;
        end
        check("multu_busy_done_cycle", {63'd0, busy}, 64'd0);
        expect32("multu_max", 32'hFFFF_FFFE, 32'h0000_0001);

        run32(MDOp_MULT, 32'hFFFF_FFFD, 32'd7);
        expect32("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run32(MDOp_DIV, 32'hFFFF_FFF9, 32'd2);
        expect32("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run32(MDOp_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        expect32("div_min_m1", 32'h0000_0000, 32'h8000_0000);
        run32(MDOp_DIVU, 32'h0000_1234, 32'd0);
        expect32("divu_by0", 32'h0000_1234, 32'hFFFF_FFFF);
        run32(MDOp_DIV, 32'hFFFF_FFFB, 32'd0);
        expect32("div_by0_neg", 32'hFFFF_FFFB, 32'hFFFF_FFFF);

        // Flush in CALC: busy drops, no done, HI/LO untouched
        @(negedge clk); start = 1'b1; op = MDOp_DIVU; A = 32'd100; B = 32'd7;
        @(negedge clk); start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        check("flush_busy", {63'd0, busy}, 64'd0);
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) done_seen++;
            @(negedge clk);
        end
        check("flush_no_done", 64'(done_seen), 64'd0);
        check("flush_hi", {32'd0, hi}, 64'hFFFF_FFFB);
        check("flush_lo", {32'd0, lo}, 64'hFFFF_FFFF);

        // Start while busy is ignored
        @(negedge clk); start = 1'b1; op = MDOp_MULT; A = 32'd6; B = 32'd7;
        @(negedge clk); start = 1'b0; lat = 0;
        while (done !== 1'b1 && lat < 60) begin
            if (lat == 4) begin
                start = 1'b1; op = MDOp_MTHI; A = 32'hDEAD_BEEF;
            end else begin
                start = 1'b0;
            end
            @(negedge clk); lat++;
        end
        start = 1'b0;
        expect32("start_in_busy", 32'd0, 32'd42);

        // MTHI then MTLO back to back
        @(negedge clk); start = 1'b1; op = MDOp_MTHI; A = 32'hA5A5_A5A5;
        @(negedge clk); op = MDOp_MTLO; A = 32'h5A5A_5A5A;
        check("mthi_done", {63'd0, done}, 64'd1);
        check("mthi_hi", {32'd0, hi}, 64'hA5A5_A5A5);
        check("mthi_busy", {63'd0, busy}, 64'd0);
        @(negedge clk); start = 1'b0;
        check("mtlo_done", {63'd0, done}, 64'd1);
        check("mtlo_lo", {32'd0, lo}, 64'h5A5A_5A5A);
        check("mtlo_busy", {63'd0, busy}, 64'd0);
        @(negedge clk);
        check("mtlo_done_clear", {63'd0, done}, 64'd0);

        // Reserved opcode
        start = 1'b1; op = 3'd6; A = 32'h1111_1111; B = 32'h2;
        @(negedge clk); start = 1'b0;
        check("rsvd_done", {63'd0, done}, 64'd0);
        check("rsvd_busy", {63'd0, busy}, 64'd0);
        check("rsvd_hilo", {hi, lo}, 64'hA5A5_A5A5_5A5A_5A5A);

        // flush wins over start in IDLE
        start = 1'b1; flush = 1'b1; op = MDOp_MULTU; A = 32'd3; B = 32'd3;
        @(negedge clk); start = 1'b0; flush = 1'b0;
        check("flush_start_busy", {63'd0, busy}, 64'd0);
        repeat (40) @(negedge clk);
        check("flush_start_hilo", {hi, lo}, 64'hA5A5_A5A5_5A5A_5A5A);

        // Asynchronous reset mid-CALC
        start = 1'b1; op = MDOp_MULTU; A = 32'h1234_5678; B = 32'h9ABC_DEF0;
        @(negedge clk); start = 1'b0;
        repeat (5) @(negedge clk);
        #1 rstn = 1'b0;
        #1;
        check("rst_mid_busy", {63'd0, busy}, 64'd0);
        check("rst_mid_done", {63'd0, done}, 64'd0);
        check("rst_mid_hilo", {hi, lo}, 64'd0);
        @(negedge clk); rstn = 1'b1;

        // WIDTH=8 sweep: directed corners plus random operands
        for (int k = 6; k < 10; k++) begin
            va[k] = 8'($urandom_range(0, 255));
            vb[k] = 8'($urandom_range(0, 255));
        end
        for (int v = 0; v < 10; v++) begin
            for (int j = 0; j < 4; j++) begin
                logic [15:0] exp8;
                exp8 = ref8(ops8[j], va[v], vb[v]);
                @(negedge clk); start8 = 1'b1; op8 = ops8[j]; a8 = va[v]; b8 = vb[v];
                @(negedge clk); start8 = 1'b0; lat = 0;
                while (done8 !== 1'b1 && lat < 30) begin
                    @(negedge clk); lat++;
                end
                check($sformatf("w8_lat_op%0d_%0h_%0h", ops8[j], va[v], vb[v]), 64'(lat), 64'd9);
                check($sformatf("w8_hilo_op%0d_%0h_%0h", ops8[j], va[v], vb[v]),
                      {48'd0, hi8, lo8}, {48'd0, exp8});
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mdu.md
# mdu

Parametrised iterative multiply/divide unit with HI/LO result registers, the multi-cycle companion to the single-cycle ALU in the execute stage. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO operations with a start/busy/done handshake. It computes products and quotients over WIDTH iterations, one bit per cycle. The pipeline controller stalls MFHI/MFLO and any new MDU op while `busy` is high.

## Interface
Parameters:
- `WIDTH`, 32: operand width; HI and LO are each WIDTH bits. Legal values are 8..64.
- `CNT_W`, $clog2(WIDTH)+1: iteration counter width. Derived; must not be overridden.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rstn`  in  1  reset, asynchronous and active-low.
- `start`  in  1  launch op; sampled only when `busy`=0.
- `op`  in  3  MDU opcode: `MDOp_MULT`, `MDOp_MULTU`, `MDOp_DIV`, `MDOp_DIVU`, `MDOp_MTHI`, `MDOp_MTLO`.
- `flush`  in  1  abort the op in flight; HI/LO keep their pre-op values.
- `A`  in  WIDTH  rs operand: multiplicand, dividend, or MTHI/MTLO data.
- `B`  in  WIDTH  rt operand: multiplier or divisor.
- `busy`  out  1  an op is in flight.
- `done`  out  1  one-cycle pulse; HI/LO updated this cycle.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.

## Operation
- States: IDLE, CALC, FIX.
- IDLE with `start`=1 and a MULT/DIV-class op:
  - Latch the op and signedness.
  - Latch |A| and |B| for signed ops; raw A and B for unsigned ops.
  - Latch the result signs: product sign = A[W-1]^B[W-1]; quotient sign likewise; remainder sign = A[W-1].
  - Clear the counter and go to CALC.
- IDLE with `start`=1 and MTHI/MTLO: write A to `hi`/`lo` at that edge. Stay in IDLE; `done` pulses in the following cycle.
- CALC: one step per cycle; the counter increments and the state moves to FIX when the counter reaches WIDTH-1.
  - Multiply step: shift-add on a 2W-bit accumulator.
  - Divide step: restoring shift-subtract on a W-bit remainder and W-bit quotient.
- FIX:
  - Apply two's-complement negation for signed ops.
  - Write `hi`/`lo`, pulse `done`, return to IDLE.
- Results:
  - MULT/MULTU: {hi,lo} = full 2W-bit product.
  - DIV/DIVU: lo = quotient, truncated toward zero; hi = remainder, with the sign of the dividend.
- Signed MIN / -1: lo = MIN, hi = 0; this is the natural wrap result.
- Divide by zero, signed or unsigned: lo = all-ones, hi = A. Latency is unchanged.
- Undefined `op` codes with `start`: ignored; no state change and no `done`.
- `start` while `busy`: ignored. The controller must hold the request until `busy` falls.
- `flush` in CALC or FIX: return to IDLE at the next edge. HI/LO are not written and `done` does not pulse. `flush` has priority over FIX completion.
- `flush` and `start` in the same IDLE cycle: `flush` wins and the op is not launched.
- `rstn` low, including mid-operation: immediately hi=0, lo=0, busy=0, done=0, state=IDLE, counter=0.

## Timing
- Start sampled at edge E0.
- `busy`=1 after E0 through E(WIDTH+1).
- CALC occupies edges E1..E(WIDTH).
- FIX executes at edge E(WIDTH+1). `hi`/`lo` are valid and `done`=1 in the cycle after E(WIDTH+1); `busy` is 0 in that same cycle.
- Total latency from start sample to result: WIDTH+1 cycles (33 at WIDTH=32).
- A new `start` is accepted in the `done` cycle, which gives back-to-back throughput of one op per WIDTH+2 cycles.
- MTHI/MTLO: `hi`/`lo` update at E0; `done` is high for the cycle after E0; `busy` never asserts.
- `done`, `busy`, `hi` and `lo` are all registered outputs; there is no combinational path from inputs to outputs.

## Structure
- Shared package: add `MDOp_*` 3-bit encodings to `ctrl_encode_def.v` alongside the `ALUOp_*` codes.
  - MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5; codes 6 and 7 are reserved.
- State encodings are local to this block.
- One sub-module, `mdu_step`: combinational single-iteration datapath, parametrised by WIDTH, that performs both the shift-add and the restoring shift-subtract. `mdu` instantiates it once.

## Test plan
- MULTU, WIDTH=32, A=0xFFFFFFFF, B=0xFFFFFFFF -> after 33 cycles: hi=0xFFFFFFFE, lo=0x00000001, one-cycle `done`.
- MULT with A=-3 (0xFFFFFFFD), B=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. DIV with A=-7, B=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV with A=0x80000000, B=0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU with A=0x1234, B=0 -> lo=0xFFFFFFFF, hi=0x1234.
- Start DIVU 100/7, raise `flush` on cycle 10 -> `busy` falls, no `done`, hi/lo unchanged. A start during busy (cycle 5 of a MULT) is ignored.
- MTHI 0xA5A5A5A5 then MTLO 0x5A5A5A5A on consecutive cycles -> both registers updated, two `done` pulses, `busy` stays 0.
- Assert `rstn` low mid-CALC -> outputs zero immediately. Repeat a randomised signed/unsigned sweep at WIDTH=8 against a reference model, checking latency = 9.
